// File: rtl/fetch_sequencer_if.sv
// Memory read port, decode issue handshake and pc redirect signals of the fetch sequencer.
// master: the sequencer; slave: the memory/decode side.
interface fetch_sequencer_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ins;
    logic [15:0] ext;
    logic        ins_en;
    logic        ins_ready;
    logic [15:0] ins_pc;
    logic        set_pc;
    logic        add_pc;
    logic [15:0] pc_arg;

    modport master (
        output mem_req, mem_addr, ins, ext, ins_en, ins_pc,
        input  mem_ack, mem_rdata, ins_ready, set_pc, add_pc, pc_arg
    );

    modport slave (
        input  mem_req, mem_addr, ins, ext, ins_en, ins_pc,
        output mem_ack, mem_rdata, ins_ready, set_pc, add_pc, pc_arg
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetches an instruction word plus optional extension word and issues the pair to decode.
// Latency: 2 cycles per one-word and 3 per two-word instruction with zero-wait memory.
// Backpressure: the issued pair is held until ins_ready; a memory request is held until mem_ack.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] EXT_MASK  = 16'hF000,
    parameter logic [15:0] EXT_MATCH = 16'hF000
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        FETCH_INS = 2'd0,
        FETCH_EXT = 2'd1,
        ISSUE     = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic        flush;
    logic        mem_req_q;
    logic [15:0] mem_addr_q;
    logic [15:0] ins_q;
    logic [15:0] ext_q;
    logic [15:0] ins_pc_q;
    logic        ins_en_q;

    logic        redirect;
    logic [15:0] target;
    logic [15:0] next_pc;
    logic [15:0] pc_inc;
    logic        ack;
    logic        needs_ext;
    logic        accept;

    always_comb begin
        redirect  = bus.set_pc | bus.add_pc;
        target    = bus.set_pc ? bus.pc_arg : (ins_pc_q + bus.pc_arg);
        next_pc   = redirect ? target : pc;
        pc_inc    = pc + 16'd1;
        // an ack only means something while our request is up
        ack       = mem_req_q & bus.mem_ack;
        needs_ext = (bus.mem_rdata & EXT_MASK) == EXT_MATCH;
        accept    = ins_en_q & bus.ins_ready;
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            state      <= FETCH_INS;
            pc         <= RESET_PC;
            flush      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            ins_q      <= 16'h0000;
            ext_q      <= 16'h0000;
            ins_pc_q   <= 16'h0000;
            ins_en_q   <= 1'b0;
        end else begin
            case (state)
                FETCH_INS, FETCH_EXT: begin
                    if (!mem_req_q) begin
                        // first cycle out of reset: no request in flight yet
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= next_pc;
                        pc         <= next_pc;
                    end else if (ack) begin
                        if (flush || redirect) begin
                            // wrong-path data: drop it and restart at the newest pc
                            flush      <= 1'b0;
                            state      <= FETCH_INS;
                            mem_addr_q <= next_pc;
                            pc         <= next_pc;
                        end else if (state == FETCH_INS) begin
                            ins_q    <= bus.mem_rdata;
                            ins_pc_q <= pc;
                            pc       <= pc_inc;
                            if (needs_ext) begin
                                state      <= FETCH_EXT;
                                mem_addr_q <= pc_inc;
                            end else begin
                                ext_q     <= 16'h0000;
                                state     <= ISSUE;
                                mem_req_q <= 1'b0;
                                ins_en_q  <= 1'b1;
                            end
                        end else begin
                            ext_q     <= bus.mem_rdata;
                            pc        <= pc_inc;
                            state     <= ISSUE;
                            mem_req_q <= 1'b0;
                            ins_en_q  <= 1'b1;
                        end
                    end else if (redirect) begin
                        // request keeps running; its data is discarded on ack
                        pc    <= target;
                        flush <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (accept || redirect) begin
                        ins_en_q   <= 1'b0;
                        state      <= FETCH_INS;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= next_pc;
                        pc         <= next_pc;
                    end
                end
                default: state <= FETCH_INS;
            endcase
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.ins      = ins_q;
    assign bus.ext      = ext_q;
    assign bus.ins_en   = ins_en_q;
    assign bus.ins_pc   = ins_pc_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized checks of fetch_sequencer against an instruction-stream reference model.
module tb_fetch_sequencer;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] EXT_MASK  = 16'hF000;
    localparam logic [15:0] EXT_MATCH = 16'hF000;

    logic cpu_clk = 1'b0;
    logic cpu_rst;

    fetch_sequencer_if bus();

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .EXT_MASK  (EXT_MASK),
        .EXT_MATCH (EXT_MATCH)
    ) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    logic [15:0] mem [0:65535];
    int          n_cmp;
    int          n_bad;
    int          n_issued;
    int          min_wait;
    int          max_wait;
    int          noise_pct;
    bit          pend;
    int          wait_left;
    logic [15:0] pend_addr;
    logic [15:0] exp_pc;
    int          gap;
    int          max_gap;

    function automatic logic needs_ext(input logic [15:0] w);
        return (w & EXT_MASK) == EXT_MATCH;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_mem_req"},  16'(bus.mem_req), 16'h0000);
        chk({tag, "_mem_addr"}, bus.mem_addr, RESET_PC);
        chk({tag, "_ins"},      bus.ins, 16'h0000);
        chk({tag, "_ext"},      bus.ext, 16'h0000);
        chk({tag, "_ins_en"},   16'(bus.ins_en), 16'h0000);
        chk({tag, "_ins_pc"},   bus.ins_pc, 16'h0000);
    endtask

    // Called at a negedge with this cycle's inputs set: answers memory, advances the model, waits one cycle.
    task automatic edge_step();
        logic        redir;
        logic [15:0] tgt;
        logic [15:0] cur;
        logic [15:0] nxt;
        logic [15:0] e_ext;
        if (!cpu_rst || !bus.mem_req) begin
            pend          = 1'b0;
            bus.mem_ack   = !cpu_rst || ($urandom_range(0, 99) < noise_pct);
            bus.mem_rdata = 16'($urandom);
        end else begin
            if (!pend) begin
                pend      = 1'b1;
                pend_addr = bus.mem_addr;
                wait_left = int'($urandom_range(min_wait, max_wait));
            end
            if (wait_left == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[pend_addr];
                pend          = 1'b0;
            end else begin
                wait_left--;
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 16'($urandom);
            end
        end

        if (!cpu_rst) begin
            exp_pc = RESET_PC;
        end else begin
            redir = bus.set_pc | bus.add_pc;
            tgt   = bus.set_pc ? bus.pc_arg : exp_pc + bus.pc_arg;
            if (bus.ins_en) begin
                cur   = mem[exp_pc];
                nxt   = exp_pc + 16'd1;
                e_ext = needs_ext(cur) ? mem[nxt] : 16'h0000;
                chk("issue_ins", bus.ins, cur);
                chk("issue_ext", bus.ext, e_ext);
                chk("issue_pc", bus.ins_pc, exp_pc);
                if (bus.ins_ready) begin
                    n_issued++;
                    exp_pc = redir ? tgt : exp_pc + (needs_ext(cur) ? 16'd2 : 16'd1);
                end else if (redir) begin
                    exp_pc = tgt;
                end
                gap = 0;
            end else begin
                if (redir) exp_pc = tgt;
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
        end
        @(negedge cpu_clk);
    endtask

    initial begin
        logic [15:0] w;
        int          n0;
        n_cmp = 0; n_bad = 0; n_issued = 0;
        min_wait = 0; max_wait = 0; noise_pct = 0;
        pend = 1'b0; wait_left = 0; pend_addr = 16'h0000;
        exp_pc = RESET_PC; gap = 0; max_gap = 0;
        cpu_rst = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0000;
        bus.ins_ready = 1'b0; bus.set_pc = 1'b0; bus.add_pc = 1'b0; bus.pc_arg = 16'h0000;

        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) w[15:12] = 4'hF;
            mem[i] = w;
        end
        mem[16'h0000] = 16'h1234; mem[16'h0001] = 16'h0001;
        mem[16'h0005] = 16'hF00A; mem[16'h0006] = 16'hBEEF;
        mem[16'h0007] = 16'h1357; mem[16'h0008] = 16'hAAAA;
        mem[16'h0010] = 16'hF123; mem[16'h0011] = 16'h5555;
        mem[16'h0040] = 16'h0440; mem[16'h0041] = 16'h0441;
        mem[16'hFFFE] = 16'h0100; mem[16'hFFFF] = 16'h2222;

        @(negedge cpu_clk);
        // reset, then first zero-wait fetch
        for (int i = 0; i < 3; i++) edge_step();
        chk_reset_values("rst");
        cpu_rst = 1'b1;
        bus.ins_ready = 1'b1;
        edge_step();
        chk("t1_req", 16'(bus.mem_req), 16'h0001);
        chk("t1_addr", bus.mem_addr, 16'h0000);
        edge_step();
        chk("t1_en", 16'(bus.ins_en), 16'h0001);
        chk("t1_ins", bus.ins, 16'h1234);
        chk("t1_ext", bus.ext, 16'h0000);
        chk("t1_pc", bus.ins_pc, 16'h0000);
        edge_step();
        chk("t1_next_addr", bus.mem_addr, 16'h0001);
        chk("t1_next_req", 16'(bus.mem_req), 16'h0001);

        // two-word instruction at 0005
        edge_step();
        bus.set_pc = 1'b1; bus.pc_arg = 16'h0005;
        edge_step();
        bus.set_pc = 1'b0;
        chk("t2_addr0", bus.mem_addr, 16'h0005);
        edge_step();
        chk("t2_addr1", bus.mem_addr, 16'h0006);
        chk("t2_req1", 16'(bus.mem_req), 16'h0001);
        chk("t2_en_low", 16'(bus.ins_en), 16'h0000);
        edge_step();
        chk("t2_en", 16'(bus.ins_en), 16'h0001);
        chk("t2_ins", bus.ins, 16'hF00A);
        chk("t2_ext", bus.ext, 16'hBEEF);
        chk("t2_pc", bus.ins_pc, 16'h0005);
        edge_step();
        chk("t2_next_addr", bus.mem_addr, 16'h0007);

        // slow memory and stalled decode
        min_wait = 3; max_wait = 3;
        bus.ins_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            edge_step();
            chk("t3_addr_hold", bus.mem_addr, 16'h0007);
            chk("t3_req_hold", 16'(bus.mem_req), 16'h0001);
            chk("t3_en_wait", 16'(bus.ins_en), 16'h0000);
        end
        min_wait = 0; max_wait = 0;
        edge_step();
        for (int k = 0; k < 4; k++) begin
            chk("t3_en_hold", 16'(bus.ins_en), 16'h0001);
            chk("t3_ins_hold", bus.ins, 16'h1357);
            chk("t3_ext_hold", bus.ext, 16'h0000);
            edge_step();
        end
        n0 = n_issued;
        bus.ins_ready = 1'b1;
        chk("t3_en_final", 16'(bus.ins_en), 16'h0001);
        edge_step();
        chk("t3_en_drop", 16'(bus.ins_en), 16'h0000);
        chk("t3_one_issue", 16'(n_issued - n0), 16'h0001);
        chk("t3_next_addr", bus.mem_addr, 16'h0008);

        // set_pc while the fetch of 0008 is outstanding
        min_wait = 2; max_wait = 2;
        edge_step();
        bus.set_pc = 1'b1; bus.pc_arg = 16'h0040;
        edge_step();
        bus.set_pc = 1'b0;
        chk("t4_addr_hold", bus.mem_addr, 16'h0008);
        chk("t4_req_hold", 16'(bus.mem_req), 16'h0001);
        min_wait = 0; max_wait = 0;
        edge_step();
        chk("t4_new_addr", bus.mem_addr, 16'h0040);
        chk("t4_no_issue", 16'(bus.ins_en), 16'h0000);
        edge_step();
        chk("t4_en", 16'(bus.ins_en), 16'h0001);
        chk("t4_ins", bus.ins, 16'h0440);
        chk("t4_pc", bus.ins_pc, 16'h0040);
        edge_step();

        // add_pc in the handshake cycle, and pc wrap
        edge_step();
        bus.set_pc = 1'b1; bus.pc_arg = 16'hFFFE;
        edge_step();
        bus.set_pc = 1'b0;
        edge_step();
        chk("t5_pc_fffe", bus.ins_pc, 16'hFFFE);
        chk("t5_en", 16'(bus.ins_en), 16'h0001);
        n0 = n_issued;
        bus.add_pc = 1'b1; bus.pc_arg = 16'h0003;
        edge_step();
        bus.add_pc = 1'b0;
        chk("t5_accepted", 16'(n_issued - n0), 16'h0001);
        chk("t5_add_addr", bus.mem_addr, 16'h0001);
        edge_step();
        bus.set_pc = 1'b1; bus.pc_arg = 16'hFFFF;
        edge_step();
        bus.set_pc = 1'b0;
        edge_step();
        chk("t5_ins_ffff", bus.ins, 16'h2222);
        chk("t5_pc_ffff", bus.ins_pc, 16'hFFFF);
        edge_step();
        chk("t5_wrap_addr", bus.mem_addr, 16'h0000);

        // reset during FETCH_EXT with a stale ack
        edge_step();
        bus.set_pc = 1'b1; bus.pc_arg = 16'h0010;
        edge_step();
        bus.set_pc = 1'b0;
        edge_step();
        min_wait = 5; max_wait = 5;
        edge_step();
        chk("t6_ext_addr", bus.mem_addr, 16'h0011);
        chk("t6_ext_req", 16'(bus.mem_req), 16'h0001);
        cpu_rst = 1'b0;
        edge_step();
        chk_reset_values("t6_rst");
        edge_step();
        min_wait = 0; max_wait = 0; noise_pct = 100;
        cpu_rst = 1'b1;
        edge_step();
        chk("t6_req", 16'(bus.mem_req), 16'h0001);
        chk("t6_addr", bus.mem_addr, RESET_PC);
        chk("t6_en_low", 16'(bus.ins_en), 16'h0000);
        edge_step();
        chk("t6_en", 16'(bus.ins_en), 16'h0001);
        chk("t6_ins", bus.ins, 16'h1234);
        chk("t6_ext", bus.ext, 16'h0000);
        chk("t6_pc", bus.ins_pc, RESET_PC);

        // random traffic against the instruction-stream model
        min_wait = 0; max_wait = 3; noise_pct = 30;
        gap = 0; max_gap = 0;
        n0 = n_issued;
        for (int i = 0; i < 3000; i++) begin
            bus.ins_ready = ($urandom_range(0, 3) != 0);
            bus.set_pc    = 1'b0;
            bus.add_pc    = 1'b0;
            bus.pc_arg    = 16'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                if (bus.ins_en && $urandom_range(0, 1) == 1) begin
                    bus.add_pc = 1'b1;
                    bus.set_pc = ($urandom_range(0, 3) == 0);
                end else begin
                    bus.set_pc = 1'b1;
                end
            end
            edge_step();
        end
        bus.set_pc = 1'b0; bus.add_pc = 1'b0;
        chk("rand_progress", 16'(n_issued - n0 > 200), 16'h0001);
        chk("rand_no_stall", 16'(max_gap <= 60), 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
